// File: rtl/mem_pkg.sv
// Shared definitions for the two-port data memory arbiter.
//   AW_DEF / DW_DEF : default address and data widths (32 x 32 memory)
//   state_t         : arbiter FSM state encoding
//   OP_RD / OP_WR   : encoding of the latched operation (write-enable bit)
package mem_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick (purely combinational).
//   i_eff_req [1:0] : masked requests (bit k = requester k)
//   i_ptr           : preferred requester when both are requesting
//   o_gnt [1:0]     : one-hot grant, all zero when nobody requests
module rr_arb2 (
  input  logic [1:0] i_eff_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_eff_req;
    if (i_eff_req == 2'b11) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer between two requesters and a
// register-style data memory with combinational read data.
//   clk, rst                       : clock, synchronous active-high reset
//   reqK/weK/addrK/wdataK (K=0,1)  : requester access request and operands
//   gntK                           : access of requester K is on the memory
//   rvalidK/rdataK                 : completion pulse and read data
//   mem_read/mem_write             : memory strobes
//   mem_addr_re/mem_addr/mem_wdata : memory read address, write address, data
//   mem_rdata                      : memory read data (combinational)
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        r_state;
  logic          r_ptr;
  logic          r_op_we;
  logic [AW-1:0] r_op_addr;
  logic [DW-1:0] r_op_wdata;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_mem_read;
  logic          r_mem_write;

  logic [1:0]    w_eff_req;
  logic [1:0]    w_gnt;
  logic          w_sel_we;

  // The requester currently on the memory drops req next cycle, so its
  // still-high request must not win again.
  assign w_eff_req = {req1 & (r_state != GNT1), req0 & (r_state != GNT0)};
  assign w_sel_we  = w_gnt[1] ? we1 : we0;

  rr_arb2 u_rr_arb2 (
    .i_eff_req (w_eff_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_op_we     <= OP_RD;
      r_op_addr   <= '0;
      r_op_wdata  <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      // Completion of the access that is on the memory this cycle.
      r_rvalid0 <= (r_state == GNT0);
      r_rvalid1 <= (r_state == GNT1);
      if ((r_state == GNT0) && (r_op_we == OP_RD)) r_rdata0 <= mem_rdata;
      if ((r_state == GNT1) && (r_op_we == OP_RD)) r_rdata1 <= mem_rdata;

      // Grant and strobes are registered alongside the state they describe.
      r_gnt0      <= w_gnt[0];
      r_gnt1      <= w_gnt[1];
      r_mem_read  <= (|w_gnt) & (w_sel_we == OP_RD);
      r_mem_write <= (|w_gnt) & (w_sel_we == OP_WR);

      // Operands are latched only on a grant, so in IDLE the memory
      // address/data outputs keep their last values.
      if (w_gnt[0]) begin
        r_state    <= GNT0;
        r_ptr      <= 1'b1;
        r_op_we    <= we0;
        r_op_addr  <= addr0;
        r_op_wdata <= wdata0;
      end else if (w_gnt[1]) begin
        r_state    <= GNT1;
        r_ptr      <= 1'b0;
        r_op_we    <= we1;
        r_op_addr  <= addr1;
        r_op_wdata <= wdata1;
      end else begin
        r_state    <= IDLE;
      end
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr_re = r_op_addr;
  assign mem_addr    = r_op_addr;
  assign mem_wdata   = r_op_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural 32x32 memory.
module tb_mem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, rvalid0, gnt1, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr_re, mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] tb_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory: clears on rst, writes on MemWrite, combinational read.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < (1 << AW); k++) tb_mem[k] <= '0;
    end else if (mem_write) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr_re];

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_re(mem_addr_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Stimulus only: one complete write through requester 1.
  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
    tick();
    req1 = 1'b0; we1 = 1'b0;
    tick();
    $display("txn wr1 addr=%0d data=%h", a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd6;
    tick(); tick();
    n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
    n_checks++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {rvalid0, rvalid1}); end
    n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    n_checks++; if (mem_addr !== 5'd0 || rdata0 !== 32'd0 || rdata1 !== 32'd0) begin n_fail++; $display("FAIL reset_regs addr=%0d rdata0=%h rdata1=%h exp=0", mem_addr, rdata0, rdata1); end
    $display("txn reset held 2 cycles with both requests");
    rst = 1'b0;
    tick();
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=01", {gnt1, gnt0}); end
    n_checks++; if (mem_read !== 1'b1 || mem_addr_re !== 5'd5) begin n_fail++; $display("FAIL reset_first_access rd=%b addr=%0d exp rd=1 addr=5", mem_read, mem_addr_re); end
    req0 = 1'b0;
    tick();
    n_checks++; if ({gnt1, gnt0, rvalid0} !== 3'b101) begin n_fail++; $display("FAIL reset_second_grant got=%b exp=101", {gnt1, gnt0, rvalid0}); end
    req1 = 1'b0;
    tick();
    n_checks++; if ({gnt1, gnt0, rvalid1} !== 3'b001) begin n_fail++; $display("FAIL reset_rvalid1 got=%b exp=001", {gnt1, gnt0, rvalid1}); end
    $display("txn post-reset grants gnt0 then gnt1");
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'hDEADBEEF;
    tick();
    n_checks++; if (gnt0 !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL wr_grant gnt0=%b wr=%b rd=%b exp 1 1 0", gnt0, mem_write, mem_read); end
    n_checks++; if (mem_addr !== 5'd3 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bus addr=%0d data=%h exp 3 deadbeef", mem_addr, mem_wdata); end
    req0 = 1'b0; we0 = 1'b0;
    tick();
    n_checks++; if (rvalid0 !== 1'b1 || gnt0 !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL wr_ack rvalid0=%b gnt0=%b wr=%b exp 1 0 0", rvalid0, gnt0, mem_write); end
    $display("txn req0 write addr=3 data=deadbeef");
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    tick();
    n_checks++; if (gnt0 !== 1'b1 || mem_read !== 1'b1 || mem_addr_re !== 5'd3) begin n_fail++; $display("FAIL rd_grant gnt0=%b rd=%b addr=%0d exp 1 1 3", gnt0, mem_read, mem_addr_re); end
    req0 = 1'b0;
    tick();
    n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data rvalid0=%b rdata0=%h exp 1 deadbeef", rvalid0, rdata0); end
    $display("txn req0 read addr=3 data=%h", rdata0);
  endtask

  task automatic test_simultaneous();
    reset_dut();
    wr1(5'd1, 32'h1111_0001);
    wr1(5'd2, 32'h2222_0002);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({gnt1, gnt0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL sim_grant cycle=%0d got=%b exp=%b", i, {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (i % 2 == 1) begin
        n_checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 32'h1111_0001) begin n_fail++; $display("FAIL sim_rdata0 cycle=%0d rv0=%b rv1=%b rdata0=%h exp 1 0 11110001", i, rvalid0, rvalid1, rdata0); end
      end else if (i > 0) begin
        n_checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== 32'h2222_0002) begin n_fail++; $display("FAIL sim_rdata1 cycle=%0d rv1=%b rv0=%b rdata1=%h exp 1 0 22220002", i, rvalid1, rvalid0, rdata1); end
      end
      $display("txn simultaneous cycle=%0d gnt0=%b gnt1=%b", i, gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    n_checks++; if ({gnt1, gnt0, rvalid1} !== 3'b001 || rdata1 !== 32'h2222_0002) begin n_fail++; $display("FAIL sim_tail got=%b rdata1=%h exp=001 22220002", {gnt1, gnt0, rvalid1}, rdata1); end
  endtask

  task automatic test_raw();
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd31; wdata1 = 32'h12345678;
    tick();
    n_checks++; if (gnt1 !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 5'd31) begin n_fail++; $display("FAIL raw_write gnt1=%b wr=%b addr=%0d exp 1 1 31", gnt1, mem_write, mem_addr); end
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd31;
    tick();
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_read !== 1'b1 || mem_addr_re !== 5'd31) begin n_fail++; $display("FAIL raw_read_grant gnt0=%b gnt1=%b rd=%b addr=%0d exp 1 0 1 31", gnt0, gnt1, mem_read, mem_addr_re); end
    n_checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h2222_0002) begin n_fail++; $display("FAIL raw_write_ack rvalid1=%b rdata1=%h exp 1 22220002", rvalid1, rdata1); end
    req0 = 1'b0;
    tick();
    n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h12345678) begin n_fail++; $display("FAIL raw_data rvalid0=%b rdata0=%h exp 1 12345678", rvalid0, rdata0); end
    $display("txn raw req1 wr addr=31 then req0 rd data=%h", rdata0);
  endtask

  task automatic test_reset_mid();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    tick();
    n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL mid_grant gnt1=%b exp=1", gnt1); end
    rst = 1'b1; req1 = 1'b0;
    tick();
    n_checks++; if ({rvalid1, gnt1, gnt0, mem_read} !== 4'b0000) begin n_fail++; $display("FAIL mid_abandon got=%b exp=0000", {rvalid1, gnt1, gnt0, mem_read}); end
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    tick();
    n_checks++; if ({gnt1, gnt0, rvalid1} !== 3'b010) begin n_fail++; $display("FAIL mid_ptr got=%b exp=010", {gnt1, gnt0, rvalid1}); end
    req0 = 1'b0;
    tick();
    n_checks++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL mid_next got=%b exp=10", {gnt1, gnt0}); end
    req1 = 1'b0;
    tick();
    $display("txn reset during gnt1 read, access abandoned");
  endtask

  task automatic test_back_to_back();
    wr1(5'd3, 32'hCAFE0003);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (gnt0 !== (i % 2 == 0) || mem_read !== (i % 2 == 0) || rvalid0 !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL b2b cycle=%0d gnt0=%b rd=%b rv0=%b exp %b %b %b", i, gnt0, mem_read, rvalid0, (i % 2 == 0), (i % 2 == 0), (i % 2 == 1));
      end
      if (i % 2 == 1) begin
        n_checks++; if (rdata0 !== 32'hCAFE0003) begin n_fail++; $display("FAIL b2b_data cycle=%0d rdata0=%h exp cafe0003", i, rdata0); end
      end
      $display("txn back-to-back cycle=%0d gnt0=%b rvalid0=%b", i, gnt0, rvalid0);
    end
    req0 = 1'b0;
    tick();
    n_checks++; if ({gnt0, rvalid0, mem_read} !== 3'b000) begin n_fail++; $display("FAIL b2b_end got=%b exp=000", {gnt0, rvalid0, mem_read}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_raw();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the 32x32 register-style data memory (5-bit address, MemRead/MemWrite strobes, combinational read data).
- Arbitrates requester 0 (CPU data port) and requester 1 (loader/debug port) round-robin.
- Drives exactly one memory access per granted cycle and returns registered read data with a valid pulse.
- Sits between the requesters and the memory; it is the only driver of the memory control, address and write-data inputs.

Parameters:
- AW, 5, address width (memory depth 2**AW = 32 words)
- DW, 32, data width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 access request, held high until gnt0
- we0  in  1  requester 0 write enable (1 = write, 0 = read), stable while req0 is high
- addr0  in  AW  requester 0 word address
- wdata0  in  DW  requester 0 write data
- gnt0  out  1  one-cycle pulse: requester 0 access is on the memory this cycle
- rvalid0  out  1  one-cycle pulse, one cycle after gnt0: access complete
- rdata0  out  DW  read data for requester 0, valid with rvalid0
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  (same as above, for requester 1)
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr_re  out  AW  to memory read address
- mem_addr  out  AW  to memory write address
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory read data (combinational)

Behaviour:
- Clocking/reset: one clock (clk); rst synchronous, active-high.
- Reset state: state=IDLE; ptr=0 (requester 0 preferred); latched op/addr/wdata=0; gnt*=0; rvalid*=0; rdata*=0; mem_read=0; mem_write=0; mem_addr*=0; mem_wdata=0.
- Reset mid-access: the in-flight access is abandoned and no rvalid is issued. A write whose GNT cycle coincides with rst is not guaranteed, because the memory clears itself on rst.
- FSM states:
  - IDLE: no memory access.
  - GNT0: requester 0 access on the memory.
  - GNT1: requester 1 access on the memory.
- Arbitration, each cycle: eff_req0 = req0 & (state!=GNT0); eff_req1 = req1 & (state!=GNT1).
  - A requester being served this cycle is masked, because it drops req in the cycle after gnt.
- Next state:
  - Neither eff_req set -> IDLE.
  - Exactly one set -> GNT of that requester.
  - Both set -> GNT of requester ptr.
- Pointer: on entering GNTk, ptr <= ~k, so the other requester wins the next tie.
- Latch: on entering GNTk, we_k, addr_k and wdata_k are captured into op registers.
  - The memory is driven only from these registers, never combinationally from requester inputs.
- Request to grant: 1 cycle. req sampled at edge N, gnt at N+1, rvalid at N+2.
- In GNTk:
  - gnt_k=1.
  - mem_addr = mem_addr_re = latched addr.
  - mem_wdata = latched wdata.
  - mem_read = ~latched_we; mem_write = latched_we.
- In IDLE: mem_read = mem_write = 0; address and data outputs hold their last values.
- Completion: at the edge ending GNTk, rvalid_k <= 1 for one cycle.
  - rdata_k <= mem_rdata for reads.
  - rdata_k is held unchanged for writes; rvalid still pulses as a write acknowledge.
- gnt and rvalid are never asserted to both requesters in the same cycle. Only one memory strobe is high at a time.
- Throughput:
  - Both requesting continuously: alternating GNT0, GNT1, GNT0, ..., i.e. one access per cycle.
  - A single requester: at most one access per 2 cycles (GNTk, IDLE, GNTk).
- Protocol requirements on requesters:
  - A requester must drop req in the cycle after its gnt, unless issuing a new request.
  - A request held high after gnt is served again no earlier than 2 cycles later; it is treated as a new request.
- Read-after-write, same address, different requesters: the write in GNTa is visible to a read in the following GNTb, because the memory read is combinational on the updated array.
- Address wrap: none. The address is used as-is; all 2**AW values are legal.

Decomposition:
- Shared package (mem_pkg):
  - AW and DW defaults.
  - State encoding constants IDLE=2'd0, GNT0=2'd1, GNT1=2'd2.
  - Op encoding OP_RD=0, OP_WR=1.
- One natural sub-module: rr_arb2. It is a combinational two-way round-robin pick taking eff_req[1:0] and ptr, returning a one-hot grant.
- FSM, latches and response registers stay in the top.

Test Plan:
- Reset: hold rst 2 cycles with req0=req1=1 -> gnt*=0, rvalid*=0, mem_read=mem_write=0. First grant after release goes to requester 0 (ptr=0).
- Single write then read:
  - req0, we0=1, addr0=5'd3, wdata0=32'hDEADBEEF -> gnt0 at N+1 with mem_write=1, mem_addr=3; rvalid0 at N+2.
  - Then a read of addr 3 -> rdata0=32'hDEADBEEF with rvalid0.
- Simultaneous requests: req0 and req1 both held (reads, addr 1 and addr 2) -> grant order GNT0, GNT1, GNT0, GNT1. No cycle has both gnt; rdata returned per requester.
- Cross-requester RAW: requester 1 writes 32'h12345678 to addr 31 in cycle k, requester 0 reads addr 31 with gnt in cycle k+1 -> rdata0=32'h12345678.
- Reset mid-access: assert rst in the GNT1 cycle of a read -> no rvalid1 next cycle, state IDLE, ptr=0.
- Single-requester back-to-back: req0 held high for 6 cycles (reads) -> gnt0 every other cycle (3 grants); mem_read low in the intervening IDLE cycles.
